// File: rtl/phrase_packer.sv
// Packs WORDS input words of WORD_W bits into one phrase for the DRAM write path.
// A frame boundary or a flush closes a partial phrase early and pads the unused slots.
module phrase_packer #(
   parameter int WORD_W = 16,
   parameter int WORDS = 8,
   parameter logic [WORD_W-1:0] PAD_WORD = '0
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic                         valid_in,
   output logic                         ready_in,
   input  logic [WORD_W-1:0]            data_in,
   input  logic                         newframe_in,
   input  logic                         flush_in,
   output logic                         valid_out,
   input  logic                         ready_out,
   output logic [WORD_W*WORDS-1:0]      data_out,
   output logic                         tuser_out,
   output logic [$clog2(WORDS+1)-1:0]   fill_out
);

   localparam int CW = $clog2(WORDS + 1);
   localparam int IW = $clog2(WORDS);
   localparam logic [CW-1:0] FULL = CW'(WORDS);

   logic [WORD_W-1:0]       slot_q [WORDS];
   logic [CW-1:0]           cnt_q;
   logic                    closePending_q;
   logic                    frame_q;

   logic                    complete;
   logic                    xfer;
   logic                    accept;
   logic                    closeReq;
   logic [CW-1:0]           cntBase;
   logic [CW-1:0]           cnt_d;
   logic                    closePending_d;
   logic [IW-1:0]           slotIdx;
   logic [WORD_W*WORDS-1:0] phrase;

   assign complete = (cnt_q == FULL) || closePending_q;
   assign xfer     = complete && (!valid_out || ready_out);
   assign ready_in = !closePending_q && !(newframe_in && (cnt_q != '0)) &&
                     ((cnt_q != FULL) || xfer);
   assign accept   = valid_in && ready_in;
   assign closeReq = flush_in || (valid_in && newframe_in && (cnt_q != '0));
   assign cntBase  = xfer ? '0 : cnt_q;
   assign cnt_d    = cntBase + CW'(accept);
   assign slotIdx  = cntBase[IW-1:0];

   // A close request only sticks if words remain after this cycle, so no empty phrase is emitted.
   assign closePending_d = (closeReq && (cnt_d != '0)) || (closePending_q && !xfer);

   always_comb begin
      phrase = '0;
      for (int k = 0; k < WORDS; k++) begin
         phrase[WORD_W*(WORDS-k)-1 -: WORD_W] = (int'(cnt_q) > k) ? slot_q[k] : PAD_WORD;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         cnt_q          <= '0;
         closePending_q <= 1'b0;
         frame_q        <= 1'b0;
         for (int k = 0; k < WORDS; k++) begin
            slot_q[k] <= '0;
         end
      end else begin
         cnt_q          <= cnt_d;
         closePending_q <= closePending_d;
         if (accept) begin
            slot_q[slotIdx] <= data_in;
            if (cntBase == '0) begin
               frame_q <= newframe_in;
            end
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         valid_out <= 1'b0;
         data_out  <= '0;
         tuser_out <= 1'b0;
         fill_out  <= '0;
      end else if (xfer) begin
         valid_out <= 1'b1;
         data_out  <= phrase;
         tuser_out <= frame_q;
         fill_out  <= cnt_q;
      end else if (ready_out) begin
         valid_out <= 1'b0;
      end
   end

endmodule

// File: tb/tb_phrase_packer.sv
// Self-checking bench for phrase_packer: a per-cycle vector table for the
// newframe/flush corner cases plus hand-written streaming, backpressure and reset sequences.
module tb_phrase_packer;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         valid;
   logic         ready;
   logic [15:0]  data;
   logic         nf;
   logic         flush;
   logic         vout;
   logic         rout;
   logic [127:0] dout;
   logic         tuser;
   logic [3:0]   fill;

   logic         valid2;
   logic         ready2;
   logic [7:0]   data2;
   logic         nf2;
   logic         flush2;
   logic         vout2;
   logic         rout2;
   logic [31:0]  dout2;
   logic         tuser2;
   logic [2:0]   fill2;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   phrase_packer #(.WORD_W(16), .WORDS(8), .PAD_WORD(16'h0000)) dut (
      .clk_in(clk), .rst_in(rst_n), .valid_in(valid), .ready_in(ready),
      .data_in(data), .newframe_in(nf), .flush_in(flush), .valid_out(vout),
      .ready_out(rout), .data_out(dout), .tuser_out(tuser), .fill_out(fill)
   );

   phrase_packer #(.WORD_W(8), .WORDS(4), .PAD_WORD(8'hFF)) dut2 (
      .clk_in(clk), .rst_in(rst_n), .valid_in(valid2), .ready_in(ready2),
      .data_in(data2), .newframe_in(nf2), .flush_in(flush2), .valid_out(vout2),
      .ready_out(rout2), .data_out(dout2), .tuser_out(tuser2), .fill_out(fill2)
   );

   typedef struct {
      logic         valid;
      logic [15:0]  data;
      logic         nf;
      logic         flush;
      logic         rout;
      logic         expReady;
      logic         expValid;
      logic [127:0] expData;
      logic         expTuser;
      logic [3:0]   expFill;
   } vec_t;

   typedef struct {
      logic [127:0] d;
      logic         t;
      logic [3:0]   f;
   } phrase_t;

   vec_t    vecs[14];
   phrase_t got[$];

   // Record every phrase that completes a handshake on the 16-bit instance.
   always @(negedge clk) begin
      if (rst_n && vout && rout) begin
         got.push_back('{dout, tuser, fill});
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic vec_t mk(input logic v, input logic [15:0] d, input logic n,
                               input logic f, input logic er, input logic ev,
                               input logic [127:0] ed, input logic et, input logic [3:0] ef);
      vec_t r;
      r.valid = v; r.data = d; r.nf = n; r.flush = f; r.rout = 1'b1;
      r.expReady = er; r.expValid = ev; r.expData = ed; r.expTuser = et; r.expFill = ef;
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] actual,
                              input logic [127:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      valid = v.valid;
      data  = v.data;
      nf    = v.nf;
      flush = v.flush;
      rout  = v.rout;
   endtask

   // Hold one word on the input until it is accepted; returns the number of stalled cycles.
   task automatic sendWord(input logic [15:0] w, input logic n, input logic f, output int stalls);
      valid = 1'b1; data = w; nf = n; flush = f; stalls = 0;
      @(negedge clk);
      while (!ready && stalls < 50) begin
         stalls++;
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      valid = 1'b0; nf = 1'b0; flush = 1'b0;
   endtask

   task automatic idle(input int n);
      valid = 1'b0; nf = 1'b0; flush = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      logic [127:0] p1;
      logic [127:0] p2;
      logic [127:0] expP;
      int           st;
      int           stallSum;
      int           accepted;
      int           waited;

      rst_n = 1'b0; valid = 1'b0; data = '0; nf = 1'b0; flush = 1'b0; rout = 1'b1;
      valid2 = 1'b0; data2 = '0; nf2 = 1'b0; flush2 = 1'b0; rout2 = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset valid_out", vout, 0);
      checkOutput("reset data_out", dout, 0);
      checkOutput("reset fill_out", fill, 0);
      checkOutput("reset tuser_out", tuser, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1 checkOutput("ready after reset", ready, 1);
      @(posedge clk);
      #1;

      // Newframe mid-phrase, then a flush together with the 5th word
      p1 = {16'h1111, 16'h2222, 16'h3333, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
      p2 = {16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888, 16'h0, 16'h0, 16'h0};
      vecs[0]  = mk(1, 16'h1111, 0, 0, 1, 0, '0, 0, 0);
      vecs[1]  = mk(1, 16'h2222, 0, 0, 1, 0, '0, 0, 0);
      vecs[2]  = mk(1, 16'h3333, 0, 0, 1, 0, '0, 0, 0);
      vecs[3]  = mk(1, 16'h4444, 1, 0, 0, 0, '0, 0, 0);
      vecs[4]  = mk(1, 16'h4444, 1, 0, 0, 0, '0, 0, 0);
      vecs[5]  = mk(1, 16'h4444, 1, 0, 1, 1, p1, 0, 3);
      vecs[6]  = mk(1, 16'h5555, 0, 0, 1, 0, '0, 0, 0);
      vecs[7]  = mk(1, 16'h6666, 0, 0, 1, 0, '0, 0, 0);
      vecs[8]  = mk(1, 16'h7777, 0, 0, 1, 0, '0, 0, 0);
      vecs[9]  = mk(1, 16'h8888, 0, 1, 1, 0, '0, 0, 0);
      vecs[10] = mk(0, 16'h0000, 0, 0, 0, 0, '0, 0, 0);
      vecs[11] = mk(0, 16'h0000, 0, 1, 1, 1, p2, 1, 5);
      vecs[12] = mk(0, 16'h0000, 0, 0, 1, 0, '0, 0, 0);
      vecs[13] = mk(0, 16'h0000, 0, 0, 1, 0, '0, 0, 0);

      got.delete();
      for (int i = 0; i < 14; i++) begin
         applyStimulus(vecs[i]);
         @(negedge clk);
         checkOutput($sformatf("vec%0d ready_in", i), ready, vecs[i].expReady);
         checkOutput($sformatf("vec%0d valid_out", i), vout, vecs[i].expValid);
         if (vecs[i].expValid) begin
            checkOutput($sformatf("vec%0d data_out", i), dout, vecs[i].expData);
            checkOutput($sformatf("vec%0d tuser_out", i), tuser, vecs[i].expTuser);
            checkOutput($sformatf("vec%0d fill_out", i), fill, vecs[i].expFill);
         end
         @(posedge clk);
         #1;
      end
      checkOutput("table phrase count", got.size(), 2);

      // 16 back-to-back words with ready_out high
      got.delete();
      rout = 1'b1;
      stallSum = 0;
      for (int i = 0; i < 16; i++) begin
         sendWord(16'(i + 1), (i == 0), 1'b0, st);
         stallSum += st;
      end
      idle(4);
      checkOutput("stream stalls", stallSum, 0);
      checkOutput("stream phrase count", got.size(), 2);
      for (int p = 0; p < 2; p++) begin
         expP = '0;
         for (int k = 0; k < 8; k++) expP[16*(8-k)-1 -: 16] = 16'(p*8 + k + 1);
         if (got.size() > p) begin
            checkOutput($sformatf("stream p%0d data", p), got[p].d, expP);
            checkOutput($sformatf("stream p%0d tuser", p), got[p].t, (p == 0));
            checkOutput($sformatf("stream p%0d fill", p), got[p].f, 8);
         end
      end

      // Backpressure: output held for 20 cycles under continuous input
      got.delete();
      rout = 1'b0;
      accepted = 0;
      for (int c = 0; c < 20; c++) begin
         valid = 1'b1; data = 16'(16'h0100 + accepted);
         @(negedge clk);
         if (ready) accepted++;
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      checkOutput("backpressure accepted", accepted, 16);
      checkOutput("backpressure ready_in", ready, 0);
      @(posedge clk);
      #1;
      valid = 1'b0;
      rout = 1'b1;
      idle(6);
      checkOutput("backpressure phrase count", got.size(), 2);
      for (int p = 0; p < 2; p++) begin
         expP = '0;
         for (int k = 0; k < 8; k++) expP[16*(8-k)-1 -: 16] = 16'(16'h0100 + p*8 + k);
         if (got.size() > p) begin
            checkOutput($sformatf("backpressure p%0d data", p), got[p].d, expP);
            checkOutput($sformatf("backpressure p%0d fill", p), got[p].f, 8);
         end
      end

      // Reset mid-phrase with a phrase held in the output register
      rout = 1'b0;
      for (int i = 0; i < 12; i++) sendWord(16'(16'h0300 + i), 1'b0, 1'b0, st);
      @(negedge clk);
      checkOutput("pre-reset valid_out", vout, 1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async reset valid_out", vout, 0);
      checkOutput("async reset fill_out", fill, 0);
      checkOutput("async reset data_out", dout, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      got.delete();
      rout = 1'b1;
      #1 checkOutput("post-reset ready_in", ready, 1);
      for (int i = 0; i < 8; i++) sendWord(16'(16'h0200 + i), 1'b0, 1'b0, st);
      idle(4);
      checkOutput("post-reset phrase count", got.size(), 1);
      expP = '0;
      for (int k = 0; k < 8; k++) expP[16*(8-k)-1 -: 16] = 16'(16'h0200 + k);
      if (got.size() > 0) begin
         checkOutput("post-reset data", got[0].d, expP);
         checkOutput("post-reset fill", got[0].f, 8);
         checkOutput("post-reset tuser", got[0].t, 0);
      end

      // 8-bit x 4 instance with 0xFF padding: two words then a flush
      valid2 = 1'b1; data2 = 8'hAA;
      @(negedge clk);
      checkOutput("w8 ready first", ready2, 1);
      @(posedge clk);
      #1 data2 = 8'hBB;
      @(negedge clk);
      checkOutput("w8 ready second", ready2, 1);
      @(posedge clk);
      #1 valid2 = 1'b0; flush2 = 1'b1;
      @(posedge clk);
      #1 flush2 = 1'b0;
      waited = 0;
      @(negedge clk);
      while (!vout2 && waited < 10) begin
         waited++;
         @(negedge clk);
      end
      checkOutput("w8 valid_out", vout2, 1);
      checkOutput("w8 data_out", dout2, 32'hAABBFFFF);
      checkOutput("w8 fill_out", fill2, 2);
      checkOutput("w8 tuser_out", tuser2, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
